// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath constants, word type and the address-width helper.
package lc3_pkg;

   localparam int LC3_WORD_W = 16;
   localparam int LC3_NREGS  = 8;

   typedef logic [LC3_WORD_W-1:0] lc3_word_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/lc3_regfile_mp_mux.sv
// Parametrised N-to-1 mux over a flat packed input; an out-of-range select yields 0.
module mux_n_to_1
   import lc3_pkg::*;
#(
   parameter int N     = 8,
   parameter int WIDTH = 16,
   localparam int SEL_W = clog2(N)
) (
   input  logic [N*WIDTH-1:0] din,
   input  logic [SEL_W-1:0]   sel,
   output logic [WIDTH-1:0]   dout
);

   always_comb begin
      dout = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (32'(sel) == k) dout = din[k*WIDTH +: WIDTH];
      end
   end

endmodule

// File: rtl/lc3_regfile_mp.sv
// Multi-port LC-3 register file: write-to-read bypass, busy scoreboard, optional registered reads.
module lc3_regfile_mp
   import lc3_pkg::*;
#(
   parameter int WIDTH  = LC3_WORD_W,
   parameter int DEPTH  = LC3_NREGS,
   parameter int NRD    = 2,
   parameter int REG_RD = 0,
   localparam int ADDR_W = clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  mark_en,
   input  logic [ADDR_W-1:0]     mark_addr,
   input  logic [NRD*ADDR_W-1:0] rd_addr,
   output logic [NRD*WIDTH-1:0]  rd_data,
   output logic [NRD-1:0]        rd_busy
);

   logic [WIDTH-1:0]       regs [DEPTH];
   logic [DEPTH-1:0]       busy;
   logic [DEPTH*WIDTH-1:0] regs_flat;
   logic [NRD*WIDTH-1:0]   comb_data, rd_data_q;
   logic [NRD-1:0]         comb_busy, rd_busy_q;

   always_comb begin
      regs_flat = '0;
      for (int unsigned r = 0; r < DEPTH; r++) regs_flat[r*WIDTH +: WIDTH] = regs[r];
   end

   for (genvar i = 0; i < NRD; i++) begin : g_port
      logic [ADDR_W-1:0] addr;
      logic [WIDTH-1:0]  mux_out, p_data;
      logic              in_range, wr_hit, mark_hit, stored_busy, p_busy;

      assign addr = rd_addr[i*ADDR_W +: ADDR_W];

      mux_n_to_1 #(.N(DEPTH), .WIDTH(WIDTH)) u_mux (
         .din  (regs_flat),
         .sel  (addr),
         .dout (mux_out)
      );

      // A same-cycle mark means a newer writer is in flight, so it overrides the bypass clear.
      always_comb begin
         in_range    = 32'(addr) < 32'(DEPTH);
         wr_hit      = wr_en && (wr_addr == addr);
         mark_hit    = mark_en && (mark_addr == addr);
         stored_busy = 1'b0;
         for (int unsigned r = 0; r < DEPTH; r++) begin
            if (32'(addr) == r) stored_busy = busy[r];
         end
         p_data = '0;
         p_busy = 1'b0;
         if (in_range) begin
            if (wr_hit) begin
               p_data = wr_data;
               p_busy = mark_hit;
            end else begin
               p_data = mux_out;
               p_busy = stored_busy;
            end
         end
      end

      assign comb_data[i*WIDTH +: WIDTH] = p_data;
      assign comb_busy[i]                = p_busy;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned r = 0; r < DEPTH; r++) regs[r] <= '0;
         busy      <= '0;
         rd_data_q <= '0;
         rd_busy_q <= '0;
      end else begin
         for (int unsigned r = 0; r < DEPTH; r++) begin
            if (wr_en && 32'(wr_addr) == r) regs[r] <= wr_data;
            if (mark_en && 32'(mark_addr) == r) busy[r] <= 1'b1;
            else if (wr_en && 32'(wr_addr) == r) busy[r] <= 1'b0;
         end
         rd_data_q <= comb_data;
         rd_busy_q <= comb_busy;
      end
   end

   assign rd_data = (REG_RD != 0) ? rd_data_q : comb_data;
   assign rd_busy = (REG_RD != 0) ? rd_busy_q : comb_busy;

endmodule

// File: tb/tb_lc3_regfile_mp.sv
// Directed bench: instance a is 8x16 combinational with 4 ports, instance b is 6-deep registered with 2 ports.
module tb_lc3_regfile_mp;

   logic clk = 1'b0;
   logic reset;

   logic        a_wr_en, a_mark_en;
   logic [2:0]  a_wr_addr, a_mark_addr;
   logic [15:0] a_wr_data;
   logic [11:0] a_rd_addr;
   logic [63:0] a_rd_data;
   logic [3:0]  a_rd_busy;

   logic        b_wr_en, b_mark_en;
   logic [2:0]  b_wr_addr, b_mark_addr;
   logic [15:0] b_wr_data;
   logic [5:0]  b_rd_addr;
   logic [31:0] b_rd_data;
   logic [1:0]  b_rd_busy;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       tag;
      int          dut;
      int          port;
      logic [15:0] data;
      logic        busy;
   } exp_t;

   exp_t sbq[$];

   lc3_regfile_mp #(.WIDTH(16), .DEPTH(8), .NRD(4), .REG_RD(0)) u_a (
      .clk(clk), .reset(reset), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
      .mark_en(a_mark_en), .mark_addr(a_mark_addr), .rd_addr(a_rd_addr),
      .rd_data(a_rd_data), .rd_busy(a_rd_busy)
   );

   lc3_regfile_mp #(.WIDTH(16), .DEPTH(6), .NRD(2), .REG_RD(1)) u_b (
      .clk(clk), .reset(reset), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
      .mark_en(b_mark_en), .mark_addr(b_mark_addr), .rd_addr(b_rd_addr),
      .rd_data(b_rd_data), .rd_busy(b_rd_busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string tag, input int dut, input int port,
                       input logic [15:0] data, input logic busy);
      exp_t e;
      e.tag = tag; e.dut = dut; e.port = port; e.data = data; e.busy = busy;
      sbq.push_back(e);
   endtask

   task automatic check();
      exp_t        e;
      logic [15:0] ad;
      logic        ab;
      #1;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         if (e.dut == 0) begin
            ad = a_rd_data[e.port*16 +: 16];
            ab = a_rd_busy[e.port];
         end else begin
            ad = b_rd_data[e.port*16 +: 16];
            ab = b_rd_busy[e.port];
         end
         total++;
         assert (ad === e.data && ab === e.busy) else begin
            bad++;
            $error("FAIL %s port%0d: data=%h busy=%b expected data=%h busy=%b",
                   e.tag, e.port, ad, ab, e.data, e.busy);
         end
      end
   endtask

   task automatic a_rd4(input logic [2:0] p0, input logic [2:0] p1,
                        input logic [2:0] p2, input logic [2:0] p3);
      a_rd_addr = {p3, p2, p1, p0};
   endtask

   task automatic b_rd2(input logic [2:0] p0, input logic [2:0] p1);
      b_rd_addr = {p1, p0};
   endtask

   initial begin
      reset = 1'b1;
      a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0; a_mark_en = 1'b0; a_mark_addr = '0;
      b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_mark_en = 1'b0; b_mark_addr = '0;
      a_rd4(0, 1, 2, 3);
      b_rd2(0, 1);
      tick();
      tick();
      reset = 1'b0;

      // state straight out of reset
      for (int p = 0; p < 4; p++) push("a_reset0", 0, p, 16'h0000, 1'b0);
      push("b_reset0", 1, 0, 16'h0000, 1'b0);
      push("b_reset0", 1, 1, 16'h0000, 1'b0);
      check();

      // load R3, mark R5, confirm, then reset clears everything
      a_wr_en = 1'b1; a_wr_addr = 3; a_wr_data = 16'hBEEF;
      b_wr_en = 1'b1; b_wr_addr = 3; b_wr_data = 16'hBEEF;
      tick();
      a_wr_en = 1'b0; b_wr_en = 1'b0;
      a_mark_en = 1'b1; a_mark_addr = 5;
      b_mark_en = 1'b1; b_mark_addr = 5;
      tick();
      a_mark_en = 1'b0; b_mark_en = 1'b0;
      a_rd4(3, 5, 3, 5);
      b_rd2(3, 5);
      push("a_pre_reset", 0, 0, 16'hBEEF, 1'b0);
      push("a_pre_reset", 0, 1, 16'h0000, 1'b1);
      check();
      push("b_pre_reset", 1, 0, 16'hBEEF, 1'b0);
      push("b_pre_reset", 1, 1, 16'h0000, 1'b1);
      tick();
      check();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int p = 0; p < 4; p++) push("a_post_reset", 0, p, 16'h0000, 1'b0);
      push("b_post_reset_q", 1, 0, 16'h0000, 1'b0);
      push("b_post_reset_q", 1, 1, 16'h0000, 1'b0);
      check();
      push("b_post_reset", 1, 0, 16'h0000, 1'b0);
      push("b_post_reset", 1, 1, 16'h0000, 1'b0);
      tick();
      check();

      // bypass in the write cycle, then from storage
      a_wr_en = 1'b1; a_wr_addr = 2; a_wr_data = 16'h1234;
      a_rd4(2, 4, 0, 0);
      push("a_bypass", 0, 0, 16'h1234, 1'b0);
      check();
      tick();
      a_wr_en = 1'b0;
      push("a_bypass_stored", 0, 0, 16'h1234, 1'b0);
      check();

      // write and mark of the same register: data bypasses, busy stays set
      a_wr_en = 1'b1; a_wr_addr = 4; a_wr_data = 16'h4444;
      a_mark_en = 1'b1; a_mark_addr = 4;
      push("a_bypass_mark", 0, 1, 16'h4444, 1'b1);
      check();
      tick();
      a_wr_en = 1'b0; a_mark_en = 1'b0;
      push("a_wr_mark_stored", 0, 1, 16'h4444, 1'b1);
      check();

      // busy scoreboard on R6
      a_mark_en = 1'b1; a_mark_addr = 6;
      tick();
      a_mark_en = 1'b0;
      a_rd4(6, 6, 0, 0);
      push("a_mark6", 0, 0, 16'h0000, 1'b1);
      check();
      a_wr_en = 1'b1; a_wr_addr = 6; a_wr_data = 16'h00FF;
      push("a_wr6_bypass", 0, 0, 16'h00FF, 1'b0);
      check();
      tick();
      a_wr_en = 1'b0;
      push("a_wr6_stored", 0, 0, 16'h00FF, 1'b0);
      check();
      a_wr_en = 1'b1; a_wr_addr = 6; a_wr_data = 16'h55AA;
      a_mark_en = 1'b1; a_mark_addr = 6;
      tick();
      a_wr_en = 1'b0; a_mark_en = 1'b0;
      push("a_wr_mark6", 0, 1, 16'h55AA, 1'b1);
      check();
      a_mark_en = 1'b1; a_mark_addr = 6;
      tick();
      a_mark_en = 1'b0;
      push("a_remark6", 0, 1, 16'h55AA, 1'b1);
      check();

      // fill all registers, then read four ports with repeated addresses
      for (int i = 0; i < 8; i++) begin
         a_wr_en = 1'b1; a_wr_addr = 3'(i); a_wr_data = 16'h1000 + 16'(i);
         tick();
      end
      a_wr_en = 1'b0;
      a_rd4(7, 0, 7, 3);
      push("a_multi", 0, 0, 16'h1007, 1'b0);
      push("a_multi", 0, 1, 16'h1000, 1'b0);
      push("a_multi", 0, 2, 16'h1007, 1'b0);
      push("a_multi", 0, 3, 16'h1003, 1'b0);
      check();

      // registered read: one-cycle latency and hold
      b_wr_en = 1'b1; b_wr_addr = 1; b_wr_data = 16'h1111;
      tick();
      b_wr_addr = 4; b_wr_data = 16'h4444;
      tick();
      b_wr_en = 1'b0;
      b_rd2(1, 4);
      push("b_reg_r1", 1, 0, 16'h1111, 1'b0);
      push("b_reg_r4", 1, 1, 16'h4444, 1'b0);
      tick();
      check();
      b_rd2(4, 4);
      push("b_reg_hold", 1, 0, 16'h1111, 1'b0);
      check();
      push("b_reg_switch", 1, 0, 16'h4444, 1'b0);
      tick();
      check();

      // registered bypass samples the written value
      b_wr_en = 1'b1; b_wr_addr = 2; b_wr_data = 16'hABCD;
      b_rd2(2, 4);
      push("b_reg_bypass", 1, 0, 16'hABCD, 1'b0);
      tick();
      b_wr_en = 1'b0;
      check();

      // out-of-range address on a 6-deep file
      b_wr_en = 1'b1; b_wr_addr = 7; b_wr_data = 16'hFFFF;
      b_mark_en = 1'b1; b_mark_addr = 7;
      b_rd2(1, 7);
      push("b_oor_keep", 1, 0, 16'h1111, 1'b0);
      push("b_oor_read", 1, 1, 16'h0000, 1'b0);
      tick();
      b_wr_en = 1'b0; b_mark_en = 1'b0;
      check();
      for (int i = 0; i < 3; i++) begin
         b_rd2(3'(2*i), 3'(2*i + 1));
         case (i)
            0: begin
               push("b_scan", 1, 0, 16'h0000, 1'b0);
               push("b_scan", 1, 1, 16'h1111, 1'b0);
            end
            1: begin
               push("b_scan", 1, 0, 16'hABCD, 1'b0);
               push("b_scan", 1, 1, 16'h0000, 1'b0);
            end
            default: begin
               push("b_scan", 1, 0, 16'h4444, 1'b0);
               push("b_scan", 1, 1, 16'h0000, 1'b0);
            end
         endcase
         tick();
         check();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
